// File: rtl/periph_uart_pkg.sv
// periph_uart_pkg: register map, STATUS bit positions and TX state encoding shared by the UART TX block.
package periph_uart_pkg;
    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_BAUD_DIV = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push into a full FIFO is taken only when a pop frees a slot the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q;
    logic do_push, do_pop;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/periph_uart_tx.sv
// periph_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO, programmable baud divisor and level irq.
module periph_uart_tx
    import periph_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        periph_mem_valid,
    output logic        periph_mem_ready,
    input  logic [31:0] periph_mem_addr,
    input  logic [31:0] periph_mem_wdata,
    input  logic [3:0]  periph_mem_wstrb,
    output logic [31:0] periph_mem_rdata,
    output logic        uart_tx,
    output logic        irq
);
    logic hit, accept, wr, push, pop, fifo_full, fifo_empty, busy, bit_end;
    logic [1:0] reg_sel;
    logic [3:0] status;
    logic [7:0] fifo_dout;
    logic [15:0] div_eff;
    logic [31:0] reg_val;
    logic ovf_q, tx_en_q, irq_en_q;
    logic [15:0] baud_q, cnt_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q;
    tx_state_e state_q;
    logic unused_bits;
    assign unused_bits = ^{periph_mem_addr[1:0], periph_mem_wdata[31:16], periph_mem_wstrb[3:2]};
    assign hit     = periph_mem_addr[31:4] == BASE_ADDR[31:4];
    assign reg_sel = periph_mem_addr[3:2];
    assign accept  = periph_mem_valid && hit && !periph_mem_ready;
    assign wr      = accept && |periph_mem_wstrb;
    assign push    = wr && reg_sel == REG_TXDATA && periph_mem_wstrb[0];
    assign busy    = state_q != TX_IDLE;
    assign bit_end = cnt_q == '0;
    // Pop either from idle or at the last stop-bit cycle so frames chain without a gap.
    assign pop     = tx_en_q && !fifo_empty && (state_q == TX_IDLE || (state_q == TX_STOP && bit_end));
    assign div_eff = baud_q == '0 ? 16'd1 : baud_q;
    assign irq     = irq_en_q && fifo_empty && !busy;
    always_comb begin
        status = '0;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_BUSY]  = busy;
        status[STAT_OVF]   = ovf_q;
        reg_val = reg_sel == REG_STATUS   ? {28'b0, status} :
                  reg_sel == REG_BAUD_DIV ? {16'b0, baud_q} :
                  reg_sel == REG_CTRL     ? {30'b0, irq_en_q, tx_en_q} : 32'b0;
    end
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(sys_clk), .rst(rst), .push_i(push), .pop_i(pop), .data_i(periph_mem_wdata[7:0]),
        .data_o(fifo_dout), .full_o(fifo_full), .empty_o(fifo_empty)
    );
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            periph_mem_ready <= 1'b0;
            periph_mem_rdata <= '0;
            ovf_q            <= 1'b0;
            baud_q           <= DEFAULT_DIV;
            tx_en_q          <= 1'b1;
            irq_en_q         <= 1'b0;
        end else begin
            periph_mem_ready <= accept;
            periph_mem_rdata <= accept ? reg_val : '0;
            if (push && fifo_full && !pop) ovf_q <= 1'b1;
            else if (wr && reg_sel == REG_STATUS && periph_mem_wstrb[0] && periph_mem_wdata[STAT_OVF]) ovf_q <= 1'b0;
            if (wr && reg_sel == REG_BAUD_DIV && periph_mem_wstrb[0]) baud_q[7:0] <= periph_mem_wdata[7:0];
            if (wr && reg_sel == REG_BAUD_DIV && periph_mem_wstrb[1]) baud_q[15:8] <= periph_mem_wdata[15:8];
            if (wr && reg_sel == REG_CTRL && periph_mem_wstrb[0]) {irq_en_q, tx_en_q} <= periph_mem_wdata[1:0];
        end
    end
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            uart_tx <= 1'b1;
        end else begin
            cnt_q <= bit_end ? div_eff - 16'd1 : cnt_q - 16'd1;
            case (state_q)
                TX_IDLE: begin
                    cnt_q <= div_eff - 16'd1;
                    if (pop) begin
                        state_q <= TX_START;
                        uart_tx <= 1'b0;
                        shift_q <= fifo_dout;
                    end
                end
                TX_START: if (bit_end) begin
                    state_q <= TX_DATA;
                    uart_tx <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    bit_q   <= '0;
                end
                TX_DATA: if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_q <= TX_STOP;
                        uart_tx <= 1'b1;
                    end else begin
                        bit_q   <= bit_q + 3'd1;
                        uart_tx <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                TX_STOP: if (bit_end) begin
                    state_q <= pop ? TX_START : TX_IDLE;
                    uart_tx <= !pop;
                    if (pop) shift_q <= fifo_dout;
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: doc/periph_uart_tx.md
PERIPH_UART_TX -- requirements
Module: periph_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0200_0000, 16-byte register window base.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter DEFAULT_DIV, default 16'd434, reset baud divisor (50 MHz / 115200).
REQ-004 SHALL have port sys_clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port periph_mem_valid  input  1  initiator request.
REQ-007 SHALL have port periph_mem_ready  output  1  responder completion strobe.
REQ-008 SHALL have port periph_mem_addr  input  32  byte address.
REQ-009 SHALL have port periph_mem_wdata  input  32  write data.
REQ-010 SHALL have port periph_mem_wstrb  input  4  byte strobes; 0 = read.
REQ-011 SHALL have port periph_mem_rdata  output  32  read data.
REQ-012 SHALL have port uart_tx  output  1  serial line, idle high.
REQ-013 SHALL have port irq  output  1  level interrupt.

Function
REQ-014 SHALL decode hit = periph_mem_addr[31:4] == BASE_ADDR[31:4]; register = addr[3:2]; a miss leaves ready low forever.
REQ-015 SHALL accept when valid && hit && !ready; ready high exactly the next cycle, one cycle wide; never two consecutive ready cycles.
REQ-016 SHALL drive rdata with the register value during the ready cycle, 0 in all other cycles.
REQ-017 SHALL apply write side effects on the edge that raises ready; writes with wstrb[0]=0 to TXDATA are ignored.
REQ-018 SHALL map 0x0 TXDATA: write pushes wdata[7:0]; reads 0.
REQ-019 SHALL map 0x4 STATUS (RO except bit3): bit0 fifo_full, bit1 fifo_empty, bit2 busy, bit3 overflow (sticky, write-1-to-clear), others 0.
REQ-020 SHALL map 0x8 BAUD_DIV: RW bits[15:0], reads zero above; value 0 behaves as 1.
REQ-021 SHALL map 0xC CTRL: RW bit0 tx_en, bit1 irq_en.
REQ-022 SHALL drop a push into a full FIFO and set overflow, unless a pop occurs the same cycle, in which case the push is accepted.
REQ-023 SHALL run TX FSM IDLE -> START -> DATA -> STOP -> IDLE; each state bit lasts max(BAUD_DIV,1) cycles; 8N1, LSB first.
REQ-024 SHALL pop in IDLE when !fifo_empty && tx_en; uart_tx low (START) the cycle after the pop; first start bit within 2 cycles of a TXDATA ready cycle into an empty, idle block.
REQ-025 SHALL go STOP -> START directly (pop at STOP end) when data pending and tx_en, giving back-to-back frames with no idle gap.
REQ-026 SHALL sample BAUD_DIV at each bit boundary; a mid-bit change affects the next bit only.
REQ-027 SHALL finish the current frame when tx_en clears mid-frame, then hold in IDLE.
REQ-028 SHALL assert busy in any state except IDLE.
REQ-029 SHALL drive irq = irq_en && fifo_empty && !busy, combinational from registers.

Reset
REQ-030 SHALL on rst: ready=0, rdata=0, uart_tx=1, FSM IDLE, FIFO empty, overflow=0, BAUD_DIV=DEFAULT_DIV, CTRL=2'b01.
REQ-031 SHALL abort any frame and any pending bus response when rst asserts mid-operation; uart_tx=1 the cycle after.

Structure
REQ-032 SHALL place register offsets, STATUS bit indices and the FSM state enum in package periph_uart_pkg.
REQ-033 SHALL instantiate one sub-module sync_fifo (parameterised width/depth, push/pop/full/empty).

Verification
REQ-034 SHALL cover: read 0x0200_0008 after reset -> ready one cycle later, rdata=32'h0000_01B2.
REQ-035 SHALL cover: BAUD_DIV=4, write TXDATA 8'hA5 -> uart_tx low within 2 cycles, then bits 1,0,1,0,0,1,0,1, stop high, 4 cycles each.
REQ-036 SHALL cover: tx_en=0, 9 writes -> STATUS=32'h0000_0009 (full+overflow); write 32'h8 to STATUS -> bit3 clears.
REQ-037 SHALL cover: access to 0x0300_0000 -> ready never asserts over 20 cycles.
REQ-038 SHALL cover: irq_en=1, two bytes queued -> irq low during frames, back-to-back frames, irq high after second stop bit.
REQ-039 SHALL cover: rst asserted mid-DATA -> uart_tx=1, STATUS=32'h0000_0002 after release.
